// File: rtl/sd_cmd_responder_if.sv
// CMD-line and card-core handshake signals of the SD card-side command responder.
// The slave modport is the responder; the master modport is the host line plus the card core.
interface sd_cmd_responder_if;
    logic        iCmd_in;
    logic        oCmd_out;
    logic        oCmd_oe;
    logic        oStrobe_out;
    logic        iAck_in;
    logic [5:0]  oCmd_index;
    logic [31:0] oCmd_argument;
    logic [37:0] iResponse;
    logic        oCrc_error;
    logic        oBusy;

    modport slave (
        input  iCmd_in, iAck_in, iResponse,
        output oCmd_out, oCmd_oe, oStrobe_out, oCmd_index, oCmd_argument, oCrc_error, oBusy
    );

    modport master (
        output iCmd_in, iAck_in, iResponse,
        input  oCmd_out, oCmd_oe, oStrobe_out, oCmd_index, oCmd_argument, oCrc_error, oBusy
    );
endinterface

// File: rtl/sd_cmd_responder.sv
// SD card-side command responder: receives 48-bit host command frames, hands valid commands
// to the card core over strobe/ack, then serializes the core's response with CRC7.
module sd_cmd_responder #(
    parameter int unsigned NCR       = 2,
    parameter bit          CRC_CHECK = 1'b1
) (
    input  logic              iClock_host,
    input  logic              iReset,
    sd_cmd_responder_if.slave bus
);
    localparam int unsigned RX_W      = 47;
    localparam int unsigned TX_W      = 40;
    localparam int unsigned RESP_W    = 38;
    localparam int unsigned CRC_W     = 7;
    localparam int unsigned BIT_CNT_W = 6;
    localparam int unsigned NCR_CNT_W = 7;

    // Receive: bit_cnt k samples frame bit 46-k; CRC covers b46..b8.
    localparam logic [BIT_CNT_W-1:0] RX_CRC_LAST = BIT_CNT_W'(38);
    localparam logic [BIT_CNT_W-1:0] RX_LAST     = BIT_CNT_W'(46);
    // Transmit: bit_cnt k drives frame bit 47-k; k == 48 releases the line.
    localparam logic [BIT_CNT_W-1:0] TX_PAY_LAST = BIT_CNT_W'(39);
    localparam logic [BIT_CNT_W-1:0] TX_END      = BIT_CNT_W'(47);
    localparam logic [NCR_CNT_W-1:0] NCR_LAST    = NCR_CNT_W'(NCR - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_EVAL,
        ST_WAIT_ACK,
        ST_NCR,
        ST_SEND
    } state_e;

    // Serial CRC7 update, polynomial x^7 + x^3 + 1.
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_e                 state_q,   state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NCR_CNT_W-1:0]   ncr_cnt_q, ncr_cnt_d;
    logic [RX_W-1:0]        rx_q,      rx_d;
    logic [TX_W-1:0]        tx_q,      tx_d;
    logic [CRC_W-1:0]       crc_q,     crc_d;
    logic                   cmd_out_q, cmd_out_d;
    logic                   cmd_oe_q,  cmd_oe_d;
    logic                   strobe_q,  strobe_d;
    logic [5:0]             index_q,   index_d;
    logic [31:0]            arg_q,     arg_d;
    logic                   crc_err_q, crc_err_d;
    logic                   busy_q,    busy_d;
    logic                   rx_ok_c;

    // Frame is good when transmission and end bits are 1 and, if enabled, CRC matches.
    assign rx_ok_c = rx_q[46] & rx_q[0] & (!CRC_CHECK || (rx_q[7:1] == crc_q));

    always_ff @(posedge iClock_host or negedge iReset) begin
        if (!iReset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            ncr_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            crc_q     <= '0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            strobe_q  <= 1'b0;
            index_q   <= '0;
            arg_q     <= '0;
            crc_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ncr_cnt_q <= ncr_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            crc_q     <= crc_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
            strobe_q  <= strobe_d;
            index_q   <= index_d;
            arg_q     <= arg_d;
            crc_err_q <= crc_err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        ncr_cnt_d = ncr_cnt_q + NCR_CNT_W'(1);
        rx_d      = rx_q;
        tx_d      = tx_q;
        crc_d     = crc_q;
        cmd_out_d = 1'b1;
        cmd_oe_d  = 1'b0;
        strobe_d  = 1'b0;
        index_d   = index_q;
        arg_d     = arg_q;
        crc_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                // A zero start bit leaves a zero-initialised CRC unchanged.
                crc_d = '0;
                if (!bus.iCmd_in) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                rx_d = {rx_q[RX_W-2:0], bus.iCmd_in};
                if (bit_cnt_q <= RX_CRC_LAST) begin
                    crc_d = crc7_step(crc_q, bus.iCmd_in);
                end
                if (bit_cnt_q == RX_LAST) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (rx_ok_c) begin
                    strobe_d = 1'b1;
                    index_d  = rx_q[45:40];
                    arg_d    = rx_q[39:8];
                    state_d  = ST_WAIT_ACK;
                end else begin
                    crc_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                // Strobe stays up through the ack edge and drops one cycle later.
                strobe_d  = 1'b1;
                ncr_cnt_d = '0;
                if (bus.iAck_in) begin
                    tx_d    = {2'b00, RESP_W'(bus.iResponse)};
                    state_d = ST_NCR;
                end
            end
            ST_NCR: begin
                if (ncr_cnt_q == NCR_LAST) begin
                    bit_cnt_d = '0;
                    crc_d     = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_cnt_q <= TX_PAY_LAST) begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = tx_q[TX_W-1];
                    tx_d      = {tx_q[TX_W-2:0], 1'b0};
                    crc_d     = crc7_step(crc_q, tx_q[TX_W-1]);
                end else if (bit_cnt_q < TX_END) begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = crc_q[CRC_W-1];
                    crc_d     = {crc_q[CRC_W-2:0], 1'b0};
                end else if (bit_cnt_q == TX_END) begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.oCmd_out      = cmd_out_q;
    assign bus.oCmd_oe       = cmd_oe_q;
    assign bus.oStrobe_out   = strobe_q;
    assign bus.oCmd_index    = index_q;
    assign bus.oCmd_argument = arg_q;
    assign bus.oCrc_error    = crc_err_q;
    assign bus.oBusy         = busy_q;
endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: a CRC-checking instance with a randomised card core,
// and a CRC-ignoring instance sharing the same CMD input with an auto-acking core.
module tb_sd_cmd_responder;
    localparam int unsigned NCR1   = 2;
    localparam int unsigned NCR2   = 2;
    localparam int          N_RAND = 30;

    typedef struct {
        bit          is_err;
        logic [5:0]  idx;
        logic [31:0] arg;
        int unsigned at;
    } ev_t;

    typedef struct {
        logic [47:0] frame;
        int unsigned at;
    } rsp_t;

    typedef struct {
        int unsigned delay;
        logic [37:0] resp;
    } plan_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;

    ev_t   evq[2][$];
    rsp_t  rspq[$];
    plan_t planq[$];

    sd_cmd_responder_if bus1 ();
    sd_cmd_responder_if bus2 ();

    sd_cmd_responder #(.NCR(NCR1), .CRC_CHECK(1'b1)) dut1 (
        .iClock_host (clk),
        .iReset      (rst_n),
        .bus         (bus1)
    );

    sd_cmd_responder #(.NCR(NCR2), .CRC_CHECK(1'b0)) dut2 (
        .iClock_host (clk),
        .iReset      (rst_n),
        .bus         (bus2)
    );

    assign bus2.iCmd_in   = bus1.iCmd_in;
    assign bus2.iAck_in   = bus2.oStrobe_out;
    assign bus2.iResponse = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_fail(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference CRC7: remainder of M(x)*x^7 divided by x^7+x^3+1, by long division.
    function automatic logic [6:0] crc7_model(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input bit tx, input logic [5:0] idx, input logic [31:0] arg,
                                             input logic [6:0] crc, input bit endb);
        return {1'b0, tx, idx, arg, crc, endb};
    endfunction

    // Drive a frame from the current negedge and record what each responder should report.
    task automatic send_frame(input logic [47:0] f);
        bit          tx_ok;
        bit          crc_ok;
        int unsigned t;
        bus1.iCmd_in = f[47];
        for (int i = 46; i >= 0; i--) begin
            @(negedge clk);
            bus1.iCmd_in = f[i];
        end
        t      = cyc + 2;
        tx_ok  = f[46] && f[0];
        crc_ok = (f[7:1] == crc7_model(f[47:8]));
        evq[0].push_back('{is_err: !(tx_ok && crc_ok), idx: f[45:40], arg: f[39:8], at: t});
        evq[1].push_back('{is_err: !tx_ok,             idx: f[45:40], arg: f[39:8], at: t});
        @(negedge clk);
        bus1.iCmd_in = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus1.oBusy || bus2.oBusy) begin
            if (n == 400) begin
                chk_fail("wait_idle_timeout");
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Card core for the CRC-checking instance: acks after a delay, plus stray acks while no strobe.
    initial begin
        plan_t       p;
        int unsigned a;
        bus1.iAck_in   = 1'b0;
        bus1.iResponse = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus1.oStrobe_out) begin
                if (planq.size() != 0) p = planq.pop_front();
                else p = '{delay: $urandom_range(0, 6), resp: 38'({$urandom, $urandom})};
                repeat (p.delay) @(negedge clk);
                bus1.iAck_in   = 1'b1;
                bus1.iResponse = p.resp;
                a = cyc + 1;
                rspq.push_back('{frame: {2'b00, p.resp, crc7_model({2'b00, p.resp}), 1'b1},
                                 at: a + NCR1 + 1});
                @(negedge clk);
                bus1.iAck_in   = 1'b0;
                bus1.iResponse = 38'({$urandom, $urandom});
            end else if ($urandom_range(0, 15) == 0) begin
                bus1.iAck_in   = 1'b1;
                bus1.iResponse = 38'({$urandom, $urandom});
                @(negedge clk);
                bus1.iAck_in = 1'b0;
            end
        end
    end

    // Command/error monitor for both instances.
    logic        sp[2];
    logic        hv[2];
    logic [5:0]  h_idx[2];
    logic [31:0] h_arg[2];
    logic        s[2], er[2], bz[2];
    logic [5:0]  ix[2];
    logic [31:0] ag[2];
    initial begin
        ev_t e;
        sp = '{1'b0, 1'b0};
        hv = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            s[0] = bus1.oStrobe_out;  s[1] = bus2.oStrobe_out;
            er[0] = bus1.oCrc_error;  er[1] = bus2.oCrc_error;
            bz[0] = bus1.oBusy;       bz[1] = bus2.oBusy;
            ix[0] = bus1.oCmd_index;  ix[1] = bus2.oCmd_index;
            ag[0] = bus1.oCmd_argument; ag[1] = bus2.oCmd_argument;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    sp[d] = 1'b0;
                    hv[d] = 1'b0;
                end else begin
                    if (er[d]) begin
                        if (evq[d].size() == 0) chk_fail($sformatf("dut%0d_unexpected_crc_error", d));
                        else begin
                            e = evq[d].pop_front();
                            chk($sformatf("dut%0d_event_is_error", d), 64'(e.is_err), 64'd1);
                            chk($sformatf("dut%0d_error_cycle", d), 64'(cyc), 64'(e.at));
                            chk($sformatf("dut%0d_busy_after_error", d), 64'(bz[d]), 64'd0);
                        end
                    end
                    if (s[d] && !sp[d]) begin
                        if (evq[d].size() == 0) begin
                            chk_fail($sformatf("dut%0d_unexpected_strobe", d));
                            hv[d] = 1'b0;
                        end else begin
                            e = evq[d].pop_front();
                            chk($sformatf("dut%0d_event_is_error", d), 64'(e.is_err), 64'd0);
                            chk($sformatf("dut%0d_strobe_cycle", d), 64'(cyc), 64'(e.at));
                            chk($sformatf("dut%0d_cmd_index", d), 64'(ix[d]), 64'(e.idx));
                            chk($sformatf("dut%0d_cmd_argument", d), 64'(ag[d]), 64'(e.arg));
                            h_idx[d] = e.idx;
                            h_arg[d] = e.arg;
                            hv[d]    = 1'b1;
                        end
                    end else if (s[d] && hv[d]) begin
                        chk($sformatf("dut%0d_index_held", d), 64'(ix[d]), 64'(h_idx[d]));
                        chk($sformatf("dut%0d_argument_held", d), 64'(ag[d]), 64'(h_arg[d]));
                    end
                    sp[d] = s[d];
                end
            end
        end
    end

    // Response monitor for the CRC-checking instance.
    initial begin
        rsp_t        r;
        logic [47:0] got;
        bit          have;
        bit          aborted;
        logic        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus1.oCmd_oe && !oe_prev) begin
                have = (rspq.size() != 0);
                if (have) begin
                    r = rspq.pop_front();
                    chk("resp_start_cycle", 64'(cyc), 64'(r.at));
                end else begin
                    chk_fail("unexpected_response");
                end
                got[47] = bus1.oCmd_out;
                aborted = 1'b0;
                for (int i = 46; i >= 0; i--) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[i] = bus1.oCmd_out;
                end
                if (!aborted) begin
                    if (have) chk("resp_frame", 64'(got), 64'(r.frame));
                    @(negedge clk);
                    chk("resp_release_oe_out", 64'({bus1.oCmd_oe, bus1.oCmd_out}), 64'(2'b01));
                end
                oe_prev = 1'b0;
            end else begin
                oe_prev = bus1.oCmd_oe;
            end
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        bit          tx;
        bit          endb;
        int unsigned kind;
        int          n;

        rst_n        = 1'b1;
        bus1.iCmd_in = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_out", 64'(bus1.oCmd_out), 64'd1);
        chk("reset_cmd_oe", 64'(bus1.oCmd_oe), 64'd0);
        chk("reset_strobe", 64'(bus1.oStrobe_out), 64'd0);
        chk("reset_index", 64'(bus1.oCmd_index), 64'd0);
        chk("reset_argument", 64'(bus1.oCmd_argument), 64'd0);
        chk("reset_crc_error", 64'(bus1.oCrc_error), 64'd0);
        chk("reset_busy", 64'(bus1.oBusy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, then CMD8 with a fixed response.
        send_frame(mk_frame(1'b1, 6'd0, 32'h0, 7'h4A, 1'b1));
        wait_idle();
        planq.push_back('{delay: 0, resp: {6'd8, 32'h0000_01AA}});
        send_frame(mk_frame(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1));
        wait_idle();

        // CMD17 with a corrupted CRC, then CMD55 with the transmission bit cleared.
        send_frame(mk_frame(1'b1, 6'd17, 32'h0, 7'h2B, 1'b1));
        wait_idle();
        send_frame(mk_frame(1'b0, 6'd55, 32'h0, 7'h32, 1'b1));
        wait_idle();

        // Slow card core: ack ten cycles after the strobe.
        arg = $urandom;
        planq.push_back('{delay: 10, resp: 38'({$urandom, $urandom})});
        send_frame(mk_frame(1'b1, 6'd13, arg, crc7_model({2'b01, 6'd13, arg}), 1'b1));
        wait_idle();

        // Reset in the middle of a response, then a fresh CMD0.
        planq.push_back('{delay: 0, resp: 38'({$urandom, $urandom})});
        send_frame(mk_frame(1'b1, 6'd0, 32'h0, 7'h4A, 1'b1));
        n = 0;
        while (!bus1.oCmd_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) chk_fail("response_start_timeout");
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_cmd_oe", 64'(bus1.oCmd_oe), 64'd0);
        chk("midreset_cmd_out", 64'(bus1.oCmd_out), 64'd1);
        chk("midreset_busy", 64'(bus1.oBusy), 64'd0);
        chk("midreset_strobe", 64'(bus1.oStrobe_out), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(mk_frame(1'b1, 6'd0, 32'h0, 7'h4A, 1'b1));
        wait_idle();

        // Random commands with occasional CRC, transmission-bit and end-bit faults.
        for (int k = 0; k < N_RAND; k++) begin
            idx  = 6'($urandom);
            arg  = $urandom;
            tx   = 1'b1;
            endb = 1'b1;
            crc  = crc7_model({2'b01, idx, arg});
            kind = $urandom_range(0, 7);
            if (kind <= 1) crc = crc ^ 7'($urandom_range(1, 127));
            else if (kind == 2) tx = 1'b0;
            else if (kind == 3) endb = 1'b0;
            send_frame(mk_frame(tx, idx, arg, crc, endb));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("dut0_events_left", 64'(evq[0].size()), 64'd0);
        chk("dut1_events_left", 64'(evq[1].size()), 64'd0);
        chk("responses_left", 64'(rspq.size()), 64'd0);
        chk("ack_plans_left", 64'(planq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
Card-side end of the SD command channel. Deserializes 48-bit host command frames from the CMD line and checks framing and CRC7. Each valid command goes to the card core over a strobe/ack handshake; the block then serializes the core-supplied 48-bit response back onto the CMD line. In the bench it takes the card role opposite the host command controller, so host-side command/response paths can be exercised end to end.

Parameters:
NCR, 2, idle cycles (line released high) between ack acceptance and the response start bit; legal range 2..64.
CRC_CHECK, 1, 1 = reject frames with a bad CRC7; 0 = ignore the CRC field.

Ports:
iClock_host  input  1  single clock; all sampling and driving on the rising edge
iReset  input  1  asynchronous, active-low reset
iCmd_in  input  1  CMD line as seen by the card; idles high
oCmd_out  output  1  CMD line drive value; 1 when not transmitting
oCmd_oe  output  1  CMD line output enable; high only while transmitting a response
oStrobe_out  output  1  valid command held on oCmd_index/oCmd_argument
iAck_in  input  1  card core accepts command; iResponse is valid in the same cycle
oCmd_index  output  6  received command index
oCmd_argument  output  32  received command argument
iResponse  input  38  response content: [37:32] index, [31:0] argument/status
oCrc_error  output  1  one-cycle pulse on a rejected frame
oBusy  output  1  high in every state except IDLE

Behaviour:
- Reset while iReset=0, asynchronous, any time including mid-frame or mid-response:
  - state IDLE, oCmd_out=1, oCmd_oe=0, oStrobe_out=0, oCmd_index=0, oCmd_argument=0, oCrc_error=0, oBusy=0.
  - After release: bit counter cleared; no partial frame resumes.
- Command frame, MSB first: b47 start=0, b46 transmission=1, b45:40 index, b39:8 argument, b7:1 CRC7, b0 end=1.
- CRC7: polynomial x^7+x^3+1, init 0, computed over b47..b8, updated serially as bits arrive.
- IDLE: first sample iCmd_in=0 is the start bit -> RECV.
- RECV: shifts 47 further bits. Call the edge that samples the end bit E.
- Evaluation at edge E:
  - Error if b46!=1, or b0!=1, or (CRC_CHECK=1 and CRC mismatch).
  - Error: oCrc_error=1 for one cycle from edge E+1; return to IDLE; no strobe.
  - OK: oCmd_index/oCmd_argument load and oStrobe_out rises at edge E+1 (state WAIT_ACK).
- WAIT_ACK:
  - oStrobe_out and the command fields hold until iAck_in is sampled high at edge A.
  - iResponse is latched at A; oStrobe_out falls at edge A+1.
  - No timeout. iCmd_in is ignored in this state.
- NCR: line stays released (oCmd_oe=0) for NCR cycles.
- SEND:
  - oCmd_oe rises together with the start bit at edge A+NCR+1.
  - Response bits: b47=0, b46=0 (card), b45:8 = latched iResponse, b7:1 = CRC7 over b47..b8, b0=1.
  - One bit per cycle; the end bit is driven at edge A+NCR+48.
  - oCmd_oe falls and oCmd_out=1 at edge A+NCR+49; return to IDLE.
- iCmd_in activity during NCR or SEND is ignored; no collision detection.
- iAck_in outside WAIT_ACK is ignored.
- Back-to-back: a new start bit is accepted from the first IDLE cycle after SEND.
- Counters: 6-bit bit counter and 7-bit NCR counter, both saturation-free and reloaded per state entry.

Test Plan:
- CMD0, arg 0x00000000, CRC 0x4A, serialized onto iCmd_in -> oStrobe_out at E+1 with oCmd_index=0, oCmd_argument=0; oCrc_error stays 0.
- CMD8, arg 0x000001AA, CRC 0x43; core acks with iResponse={6'd8, 32'h000001AA} -> oCmd_oe at A+3 (NCR=2); 48 bits driven = 0x08_000001AA with valid CRC7 and end bit 1; oCmd_oe falls at A+51.
- CMD17, arg 0, CRC corrupted to 0x2B -> oCrc_error pulses once at E+1; no strobe; oBusy=0 from E+1. Repeat with CRC_CHECK=0 -> strobe asserted.
- Transmission bit forced to 0 in an otherwise valid CMD55 frame (CRC 0x32) -> framing error pulse; no strobe.
- Ack delayed 10 cycles -> oStrobe_out and command fields stable throughout; response start at A+NCR+1; iAck_in pulses before the frame are ignored.
- iReset driven low mid-response (bit 20) -> oCmd_oe=0 and oCmd_out=1 immediately; after release, a fresh CMD0 frame is received correctly.
